jtag_tap_sequencer: RTL and testbench

- Command-driven JTAG master that sequences the TAP of the onboard BIST target; generates TCK/TMS/TDI from a system clock and captures TDO.
- Replaces hand-timed TMS/TDI stimulus with four commands: TAP reset, IR scan, DR scan and Run-Test/Idle dwell. Drives JB_TCK/JB_TMS/JB_TDI/JB_TDO of OnboardTop.
- The TAP home state between commands is Run-Test/Idle.

---
 rtl/jtag_tap_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_jtag_tap_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sequencer.sv
// Command-driven JTAG master: turns RESET / IR scan / DR scan / Run-Test dwell commands
// into TCK/TMS/TDI sequences. The TAP is left in Run-Test/Idle between commands.
module jtag_tap_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [4:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DWELL, S_RESP} state_t;

  state_t               state_q, state_d;
  logic                 synced_q, synced_d;
  logic [1:0]           op_q, op_d;
  logic [4:0]           len_q, len_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [9:0]           pre_q, pre_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [MAX_LEN-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 tck_q, tck_d;
  logic                 tms_q, tms_d;
  logic                 tdi_q, tdi_d;
  logic [PW-1:0]        phase_q, phase_d;

  logic       tck_active, rise, fall, start, illegal;
  logic [9:0] pre_sel;
  logic [4:0] pre_len;

  assign tck_active = (state_q == S_PRE) || (state_q == S_SHIFT) ||
                      (state_q == S_POST) || (state_q == S_DWELL);
  assign rise    = tck_active && !tck_q && (phase_q == PHASE_LAST);
  assign fall    = tck_active &&  tck_q && (phase_q == PHASE_LAST);
  assign illegal = (cmd_op != OP_RESET) && ((cmd_len == 5'd0) || (int'(cmd_len) > MAX_LEN));

  // TMS prefix, LSB first: an unsynced TAP gets the 6-TCK reset walk ahead of the scan entry.
  always_comb begin
    pre_sel = 10'b00_0001_1111;
    pre_len = 5'd6;
    case (cmd_op)
      OP_IR: begin
        pre_sel = synced_q ? 10'b00_0000_0011 : 10'b00_1101_1111;
        pre_len = synced_q ? 5'd4 : 5'd10;
      end
      OP_DR: begin
        pre_sel = synced_q ? 10'b00_0000_0001 : 10'b00_0101_1111;
        pre_len = synced_q ? 5'd3 : 5'd9;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    synced_d    = synced_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    phase_d     = phase_q;
    start       = 1'b0;

    if (tck_active) begin
      if (phase_q == PHASE_LAST) begin
        phase_d = '0;
        tck_d   = !tck_q;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    if (rise && state_q == S_SHIFT) begin
      rsp_data_d[idx_q] = TDO;
      idx_d             = idx_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op;
          len_d      = cmd_len;
          data_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          idx_d      = '0;
          if (illegal) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            synced_d = 1'b1;
            start    = 1'b1;
            if (cmd_op == OP_RUN && synced_q) begin
              state_d = S_DWELL;
              cnt_d   = cmd_len;
            end else begin
              state_d = S_PRE;
              pre_d   = pre_sel;
              cnt_d   = pre_len;
            end
          end
        end
      end
      S_PRE: begin
        if (fall) begin
          if (cnt_q > 5'd1) begin
            cnt_d = cnt_q - 1'b1;
            pre_d = pre_q >> 1;
            start = 1'b1;
          end else if (op_q == OP_IR || op_q == OP_DR) begin
            state_d = S_SHIFT;
            cnt_d   = len_q;
            start   = 1'b1;
          end else if (op_q == OP_RUN) begin
            state_d = S_DWELL;
            cnt_d   = len_q;
            start   = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_SHIFT: begin
        if (fall) begin
          data_d = data_q >> 1;
          start  = 1'b1;
          if (cnt_q > 5'd1) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_POST;
            cnt_d   = 5'd2;
          end
        end
      end
      S_POST, S_DWELL: begin
        if (fall) begin
          if (cnt_q > 5'd1) begin
            cnt_d = cnt_q - 1'b1;
            start = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new TCK period begins with TCK low; TMS/TDI for that period come from the next state.
    if (start) begin
      tck_d   = 1'b0;
      phase_d = '0;
      case (state_d)
        S_PRE:   begin tms_d = pre_d[0];         tdi_d = 1'b0;      end
        S_SHIFT: begin tms_d = (cnt_d == 5'd1);  tdi_d = data_d[0]; end
        S_POST:  begin tms_d = (cnt_d == 5'd2);  tdi_d = 1'b0;      end
        default: begin tms_d = 1'b0;             tdi_d = 1'b0;      end
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      synced_q    <= 1'b0;
      op_q        <= OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      synced_q    <= synced_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      phase_q     <= phase_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Scoreboard bench for jtag_tap_sequencer: stimulus queues expected TMS/TDI traces and
// responses; a monitor logs every TCK rise and checks each response as it is consumed.
module tb_jtag_tap_sequencer;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 16;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [4:0]         cmd_len = 5'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               TCK, TMS, TDI, TDO;

  logic tdo_const = 1'b0;
  logic loop_q = 1'b0;

  jtag_tap_sequencer #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CLK = ~CLK;

  // Target model: TDO follows TDI delayed by one TCK, or is tied high.
  assign TDO = tdo_const ? 1'b1 : loop_q;
  initial forever begin
    @(posedge TCK);
    loop_q = TDI;
  end

  typedef struct {
    logic [63:0] tms;
    logic [63:0] tdi;
    int          n;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_rsp = 0;

  logic [63:0] log_tms = '0;
  logic [63:0] log_tdi = '0;
  int          log_n = 0;
  logic        gap_bad = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [63:0] tms, input logic [63:0] tdi, input int n,
                              input logic [15:0] data, input logic err);
    exp_t e;
    e.tms = tms; e.tdi = tdi; e.n = n; e.data = data; e.err = err;
    return e;
  endfunction

  // Monitor: logs TCK rises, checks period, compares each consumed response.
  initial begin
    exp_t e;
    logic tck_prev;
    int   cyc;
    int   last_rise;
    tck_prev  = 1'b0;
    cyc       = 0;
    last_rise = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (TCK && !tck_prev) begin
        if (log_n > 0 && (cyc - last_rise) != 2 * CLK_DIV) gap_bad = 1'b1;
        last_rise = cyc;
        log_tms   = {log_tms[62:0], TMS};
        log_tdi   = {log_tdi[62:0], TDI};
        log_n++;
      end
      tck_prev = TCK;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        $display("rsp %0d: data=0x%0h err=%0b tcks=%0d", n_rsp, rsp_data, rsp_err, log_n);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("tck_count[%0d]", n_rsp), 64'(log_n), 64'(e.n));
          chk($sformatf("tms_trace[%0d]", n_rsp), log_tms, e.tms);
          chk($sformatf("tdi_trace[%0d]", n_rsp), log_tdi, e.tdi);
          chk($sformatf("rsp_data[%0d]", n_rsp), 64'(rsp_data), 64'(e.data));
          chk($sformatf("rsp_err[%0d]", n_rsp), 64'(rsp_err), 64'(e.err));
          chk($sformatf("tck_period[%0d]", n_rsp), 64'(gap_bad), 64'd0);
        end
        log_tms = '0;
        log_tdi = '0;
        log_n   = 0;
        gap_bad = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 5000) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data,
                       input exp_t e);
    wait_ready();
    exp_q.push_back(e);
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tck", 64'(TCK), 64'd0);
    chk("rst_tms", 64'(TMS), 64'd1);
    chk("rst_tdi", 64'(TDI), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_release", 64'(cmd_ready), 64'd1);

    // Unsynced IR scan: implicit reset walk, then 1,1,0,0 / 4 bits / 1,0.
    issue(OP_IR, 5'd4, 16'h0005,
          mk(64'b1111101100000110, 64'b0000000000101000, 16, 16'h000A, 1'b0));
    // Synced 13-bit DR loopback.
    issue(OP_DR, 5'd13, 16'h1555,
          mk(64'b100000000000000110, 64'({3'b000, 13'b1010101010101, 2'b00}), 18, 16'h0AAA, 1'b0));
    // Run-Test dwell ignores cmd_data.
    issue(OP_RUN, 5'd16, 16'hFFFF, mk(64'd0, 64'd0, 16, 16'h0000, 1'b0));

    // Illegal length 0 with the response held off for 5 cycles.
    wait_ready();
    rsp_ready = 1'b0;
    issue(OP_DR, 5'd0, 16'h1234, mk(64'd0, 64'd0, 0, 16'h0000, 1'b1));
    @(posedge CLK); #1;
    chk("err_rsp_latency", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("hold_rsp_valid[%0d]", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("hold_cmd_ready[%0d]", i), 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    issue(OP_IR, 5'd17, 16'hFFFF, mk(64'd0, 64'd0, 0, 16'h0000, 1'b1));

    // RESET ignores cmd_len.
    issue(OP_RESET, 5'd0, 16'hFFFF, mk(64'b111110, 64'd0, 6, 16'h0000, 1'b0));

    // Single-bit DR: the only shift bit carries TMS=1.
    wait_ready();
    tdo_const = 1'b1;
    issue(OP_DR, 5'd1, 16'h0001, mk(64'b100110, 64'b000100, 6, 16'h0001, 1'b0));

    // Full-width DR loopback.
    wait_ready();
    tdo_const = 1'b0;
    issue(OP_DR, 5'd16, 16'hBEEF,
          mk(64'({3'b100, 15'd0, 1'b1, 2'b10}), 64'({3'b000, 16'hF77D, 2'b00}), 21, 16'h7DDE, 1'b0));

    // Abort a DR scan at its 3rd shift bit.
    issue(OP_DR, 5'd8, 16'h00A5, mk(64'd0, 64'd0, 0, 16'h0000, 1'b0));
    g = 0;
    while (log_n < 6 && g < 1000) begin
      @(posedge CLK);
      g++;
    end
    if (log_n < 6) chk("abort_wait_timeout", 64'(log_n), 64'd6);
    #2;
    chk("tck_high_before_abort", 64'(TCK), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("abort_tck", 64'(TCK), 64'd0);
    chk("abort_tms", 64'(TMS), 64'd1);
    chk("abort_tdi", 64'(TDI), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    exp_q.delete();
    log_tms = '0;
    log_tdi = '0;
    log_n   = 0;
    gap_bad = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    // After the abort the TAP is unsynced again: reset walk precedes the DR scan.
    issue(OP_DR, 5'd3, 16'h0005,
          mk(64'b11111010000110, 64'b00000000010100, 14, 16'h0002, 1'b0));

    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge CLK);
      g++;
    end
    repeat (2) @(posedge CLK);
    chk("pending_rsp", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
